ex_alu_stage: RTL and testbench
===============================

// Module: ex_alu_stage
// PURPOSE
//  Execute stage of the pipelined MIPS core, and the consumer of the 3-bit ALUControl code
//  produced by the ALU control decoder.
//  Combinationally evaluates the ALU operation on forwarded operands. Registers result, flags and
//  writeback control into the EX/MEM pipeline register.
//  Supports stall (hold) and flush (bubble insertion) from the hazard unit.
// PARAMETERS
//  WIDTH       32  datapath width in bits
//  REG_ADDR_W  5   destination register index width
// PORTS
//  Clk          in   1           clock; all state updates on rising edge
//  Reset        in   1           synchronous, active-high reset
//  Stall        in   1           hold EX/MEM register contents
//  Flush        in   1           replace captured instruction with bubble
//  InValid      in   1           instruction in EX is valid
//  ALUControl   in   3           000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT
//  SrcA         in   WIDTH       operand A (post-forwarding)
//  SrcB         in   WIDTH       operand B (post-forwarding / immediate mux)
//  RegWrite     in   1           instruction writes register file
//  WriteReg     in   REG_ADDR_W  destination register
//  OutValid     out  1           EX/MEM entry valid
//  ALUResult    out  WIDTH       registered result
//  Zero         out  1           registered (result == 0), for branch resolution
//  Overflow     out  1           registered signed overflow (ADD/SUB only)
//  RegWriteOut  out  1           registered RegWrite & InValid (see CONFIGURATION)
//  WriteRegOut  out  REG_ADDR_W  registered destination register
// BEHAVIOUR
//  - Latency is 1 cycle: operands presented in cycle N appear on the outputs after edge N+1.
//  - Reset: all outputs are 0, including OutValid, ALUResult, Zero, Overflow, RegWriteOut
//    and WriteRegOut.
//  - Priority at each edge is Reset > Flush > Stall > capture.
//  - Flush: OutValid, RegWriteOut, Overflow, ALUResult and WriteRegOut are cleared to 0.
//    Zero is set to 1, consistent with ALUResult being 0.
//  - Flush together with Stall in the same cycle: the flush wins.
//  - Stall: every output holds its previous value. Inputs are ignored.
//  - Capture: all outputs load their next values.
//  - InValid=0 on capture: OutValid=0 and RegWriteOut=0. Result and flags are still
//    computed and stored, but are don't-care for downstream logic.
//  - Arithmetic uses WIDTH-bit modulo wrap. Results never trap unless ALU_OVF_TRAP_EN
//    is defined.
//  - ADD overflow = (A[msb]==B[msb]) & (R[msb]!=A[msb]).
//  - SUB overflow = (A[msb]!=B[msb]) & (R[msb]!=A[msb]).
//  - SLT result = {0..., (A-B)[msb] ^ ovf_sub}. This is a correct signed compare even when
//    the subtraction overflows; Overflow reads 0 for SLT.
//  - AND and OR set Overflow to 0.
//  - Unused codes 011/100/101 give ALUResult=0, Zero=1, Overflow=0, and the writeback
//    control passes through unchanged.
// CONFIGURATION
//  - ALU_OVF_TRAP_EN defined:
//    - Adds output OvfTrap (1 bit, registered, reset 0).
//    - On capture of a valid ADD/SUB that overflows, OvfTrap=1 and RegWriteOut=0, so the
//      destination is not written.
//    - OvfTrap clears on the next capture or flush, and holds on stall.
//  - ALU_OVF_TRAP_EN undefined:
//    - No OvfTrap port; the Overflow flag is informational only.
//    - RegWriteOut = RegWrite & InValid.
// STRUCTURE
//  - Shared package alu_pkg:
//    - ALU_AND=3'b000, ALU_OR=3'b001, ALU_ADD=3'b010, ALU_SUB=3'b110, ALU_SLT=3'b111
//    - alu_ctrl_t (3-bit)
//    - ALU control decoder also imports alu_pkg.
//  - One sub-module, alu_core: purely combinational, (A,B,ALUControl) -> (Result, Zero, Overflow).
//  - ex_alu_stage holds only the EX/MEM register and the stall/flush/trap logic.
// TESTING
//  1. Reset held 2 cycles, then released -> all outputs 0; first capture after release is
//     seen one edge later.
//  2. ADD 0x7FFFFFFF+1, InValid=1, RegWrite=1, WriteReg=5 -> ALUResult 0x80000000,
//     Overflow=1, Zero=0, WriteRegOut=5; RegWriteOut=1 (trap off) or 0 with OvfTrap=1
//     (trap on).
//  3. SUB 7-7 -> ALUResult 0, Zero=1. SLT 0x80000000 vs 1 -> 1. SLT 0x7FFFFFFF vs
//     0xFFFFFFFF -> 0 (overflowing compare).
//  4. AND 0xF0F0 & 0x0FF0 -> 0x00F0. OR -> 0xFFF0. Code 3'b100 -> ALUResult 0, Zero=1,
//     Overflow=0.
//  5. Capture ADD 2+3, then Stall 3 cycles with changing inputs -> outputs hold 5 throughout.
//     Stall+Flush together -> OutValid=0, RegWriteOut=0, ALUResult=0.
//  6. Reset asserted mid-stream with Stall=1 and valid ops queued -> outputs 0 at the next
//     edge; normal capture resumes the cycle after Reset deasserts.

Source files
------------

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - ALU control codes shared by the ALU control decoder and the EX stage
package alu_pkg;

  typedef logic [2:0] alu_ctrl_t;

  localparam alu_ctrl_t ALU_AND = 3'b000;
  localparam alu_ctrl_t ALU_OR  = 3'b001;
  localparam alu_ctrl_t ALU_ADD = 3'b010;
  localparam alu_ctrl_t ALU_SUB = 3'b110;
  localparam alu_ctrl_t ALU_SLT = 3'b111;

endpackage

// File: rtl/alu_core.sv
// rtl/alu_core.sv - combinational ALU: (a, b, ctrl) -> (result, zero, overflow)
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  alu_ctrl_t        ctrl,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow
);

  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic             ovf_add;
  logic             ovf_sub;

  assign sum     = a + b;
  assign diff    = a - b;
  assign ovf_add = (a[WIDTH-1] == b[WIDTH-1]) & (sum[WIDTH-1]  != a[WIDTH-1]);
  assign ovf_sub = (a[WIDTH-1] != b[WIDTH-1]) & (diff[WIDTH-1] != a[WIDTH-1]);

  always_comb begin
    result   = '0;
    overflow = 1'b0;
    case (ctrl)
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_ADD: begin
        result   = sum;
        overflow = ovf_add;
      end
      ALU_SUB: begin
        result   = diff;
        overflow = ovf_sub;
      end
      // Sign of the true difference, corrected when the subtraction wraps
      ALU_SLT: result = {{(WIDTH-1){1'b0}}, diff[WIDTH-1] ^ ovf_sub};
      default: ;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/ex_alu_stage.sv
// rtl/ex_alu_stage.sv - EX stage with EX/MEM register, stall/flush; ALU_OVF_TRAP_EN adds OvfTrap
module ex_alu_stage
  import alu_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  Stall,
  input  logic                  Flush,
  input  logic                  InValid,
  input  alu_ctrl_t             ALUControl,
  input  logic [WIDTH-1:0]      SrcA,
  input  logic [WIDTH-1:0]      SrcB,
  input  logic                  RegWrite,
  input  logic [REG_ADDR_W-1:0] WriteReg,
  output logic                  OutValid,
  output logic [WIDTH-1:0]      ALUResult,
  output logic                  Zero,
  output logic                  Overflow,
  output logic                  RegWriteOut,
  output logic [REG_ADDR_W-1:0] WriteRegOut
`ifdef ALU_OVF_TRAP_EN
  ,
  output logic                  OvfTrap
`endif
);

  logic [WIDTH-1:0] alu_result;
  logic             alu_zero;
  logic             alu_overflow;
  logic             reg_write_next;

  alu_core #(.WIDTH(WIDTH)) u_alu_core (
    .a        (SrcA),
    .b        (SrcB),
    .ctrl     (ALUControl),
    .result   (alu_result),
    .zero     (alu_zero),
    .overflow (alu_overflow)
  );

`ifdef ALU_OVF_TRAP_EN
  // Overflow is only ever raised by ADD/SUB, so it alone identifies a trapping op
  logic trap_next;
  assign trap_next      = InValid & alu_overflow;
  assign reg_write_next = RegWrite & InValid & ~trap_next;
`else
  assign reg_write_next = RegWrite & InValid;
`endif

  always_ff @(posedge Clk) begin
    if (Reset) begin
      OutValid    <= 1'b0;
      ALUResult   <= '0;
      Zero        <= 1'b0;
      Overflow    <= 1'b0;
      RegWriteOut <= 1'b0;
      WriteRegOut <= '0;
`ifdef ALU_OVF_TRAP_EN
      OvfTrap     <= 1'b0;
`endif
    end else if (Flush) begin
      OutValid    <= 1'b0;
      ALUResult   <= '0;
      Zero        <= 1'b1;
      Overflow    <= 1'b0;
      RegWriteOut <= 1'b0;
      WriteRegOut <= '0;
`ifdef ALU_OVF_TRAP_EN
      OvfTrap     <= 1'b0;
`endif
    end else if (!Stall) begin
      OutValid    <= InValid;
      ALUResult   <= alu_result;
      Zero        <= alu_zero;
      Overflow    <= alu_overflow;
      RegWriteOut <= reg_write_next;
      WriteRegOut <= WriteReg;
`ifdef ALU_OVF_TRAP_EN
      OvfTrap     <= trap_next;
`endif
    end
  end

endmodule

// File: tb/tb_ex_alu_stage.sv
// tb/tb_ex_alu_stage.sv - directed self-checking bench for ex_alu_stage
module tb_ex_alu_stage;

  logic        Clk = 1'b0;
  logic        Reset, Stall, Flush, InValid, RegWrite;
  logic [2:0]  ALUControl;
  logic [31:0] SrcA, SrcB;
  logic [4:0]  WriteReg;
  logic        OutValid, Zero, Overflow, RegWriteOut;
  logic [31:0] ALUResult;
  logic [4:0]  WriteRegOut;
  logic        trap_obs;

  int compared   = 0;
  int mismatched = 0;

`ifdef ALU_OVF_TRAP_EN
  localparam bit TRAP = 1'b1;
  logic OvfTrap;
  assign trap_obs = OvfTrap;
`else
  localparam bit TRAP = 1'b0;
  assign trap_obs = 1'b0;
`endif

  always #5 Clk = ~Clk;

  ex_alu_stage dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .Stall       (Stall),
    .Flush       (Flush),
    .InValid     (InValid),
    .ALUControl  (ALUControl),
    .SrcA        (SrcA),
    .SrcB        (SrcB),
    .RegWrite    (RegWrite),
    .WriteReg    (WriteReg),
    .OutValid    (OutValid),
    .ALUResult   (ALUResult),
    .Zero        (Zero),
    .Overflow    (Overflow),
    .RegWriteOut (RegWriteOut),
    .WriteRegOut (WriteRegOut)
`ifdef ALU_OVF_TRAP_EN
    ,
    .OvfTrap     (OvfTrap)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic expect_all(input string tag, input logic ov, input logic [31:0] res,
                            input logic z, input logic ovf, input logic rw,
                            input logic [4:0] wr, input logic trap);
    chk({tag, ".valid"}, {31'd0, OutValid}, {31'd0, ov});
    chk({tag, ".result"}, ALUResult, res);
    chk({tag, ".zero"}, {31'd0, Zero}, {31'd0, z});
    chk({tag, ".ovf"}, {31'd0, Overflow}, {31'd0, ovf});
    chk({tag, ".regwrite"}, {31'd0, RegWriteOut}, {31'd0, rw});
    chk({tag, ".writereg"}, {27'd0, WriteRegOut}, {27'd0, wr});
`ifdef ALU_OVF_TRAP_EN
    chk({tag, ".trap"}, {31'd0, trap_obs}, {31'd0, trap});
`else
    if (trap) $display("note: trap expectation ignored in %s", tag);
`endif
  endtask

  task automatic set_in(input logic [2:0] ctrl, input logic [31:0] a, input logic [31:0] b,
                        input logic iv, input logic rw, input logic [4:0] wr);
    ALUControl = ctrl;
    SrcA       = a;
    SrcB       = b;
    InValid    = iv;
    RegWrite   = rw;
    WriteReg   = wr;
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  initial begin
    Reset = 1'b1; Stall = 1'b0; Flush = 1'b0;
    set_in(3'b010, 32'd9, 32'd9, 1'b1, 1'b1, 5'd3);

    // 1. reset held two cycles, then first capture
    tick();
    tick();
    expect_all("reset", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
    Reset = 1'b0;
    set_in(3'b010, 32'd1, 32'd1, 1'b1, 1'b1, 5'd2);
    tick();
    expect_all("first_add", 1'b1, 32'd2, 1'b0, 1'b0, 1'b1, 5'd2, 1'b0);

    // 2. signed ADD overflow
    set_in(3'b010, 32'h7FFF_FFFF, 32'h1, 1'b1, 1'b1, 5'd5);
    tick();
    expect_all("add_ovf", 1'b1, 32'h8000_0000, 1'b0, 1'b1, !TRAP, 5'd5, TRAP);

    // trap (if enabled) clears on next capture
    set_in(3'b110, 32'd7, 32'd7, 1'b1, 1'b1, 5'd6);
    tick();
    expect_all("sub_zero", 1'b1, 32'h0, 1'b1, 1'b0, 1'b1, 5'd6, 1'b0);

    set_in(3'b110, 32'h8000_0000, 32'h1, 1'b1, 1'b1, 5'd7);
    tick();
    expect_all("sub_ovf", 1'b1, 32'h7FFF_FFFF, 1'b0, 1'b1, !TRAP, 5'd7, TRAP);

    // 3. SLT, including the overflowing compare
    set_in(3'b111, 32'h8000_0000, 32'h1, 1'b1, 1'b1, 5'd8);
    tick();
    expect_all("slt_neg", 1'b1, 32'h1, 1'b0, 1'b0, 1'b1, 5'd8, 1'b0);

    set_in(3'b111, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1, 5'd9);
    tick();
    expect_all("slt_wrap", 1'b1, 32'h0, 1'b1, 1'b0, 1'b1, 5'd9, 1'b0);

    // 4. logic ops and an unused code
    set_in(3'b000, 32'h0000_F0F0, 32'h0000_0FF0, 1'b1, 1'b1, 5'd10);
    tick();
    expect_all("and", 1'b1, 32'h0000_00F0, 1'b0, 1'b0, 1'b1, 5'd10, 1'b0);

    set_in(3'b001, 32'h0000_F0F0, 32'h0000_0FF0, 1'b1, 1'b0, 5'd11);
    tick();
    expect_all("or", 1'b1, 32'h0000_FFF0, 1'b0, 1'b0, 1'b0, 5'd11, 1'b0);

    set_in(3'b100, 32'h1234_5678, 32'h1111_1111, 1'b1, 1'b1, 5'd12);
    tick();
    expect_all("unused", 1'b1, 32'h0, 1'b1, 1'b0, 1'b1, 5'd12, 1'b0);

    // bubble in EX: result still computed, writeback suppressed
    set_in(3'b010, 32'd10, 32'd20, 1'b0, 1'b1, 5'd13);
    tick();
    expect_all("invalid", 1'b0, 32'd30, 1'b0, 1'b0, 1'b0, 5'd13, 1'b0);

    // 5. capture 2+3, then stall three cycles with changing inputs
    set_in(3'b010, 32'd2, 32'd3, 1'b1, 1'b1, 5'd4);
    tick();
    expect_all("add5", 1'b1, 32'd5, 1'b0, 1'b0, 1'b1, 5'd4, 1'b0);
    Stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_in(3'b110, 32'd100 + i, 32'd1, 1'b0, 1'b0, 5'd20 + 5'(i));
      tick();
      expect_all($sformatf("stall%0d", i), 1'b1, 32'd5, 1'b0, 1'b0, 1'b1, 5'd4, 1'b0);
    end
    Flush = 1'b1;
    tick();
    expect_all("stall_flush", 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0);
    Stall = 1'b0; Flush = 1'b0;

    // flush alone after an overflowing capture clears flags and trap
    set_in(3'b010, 32'h8000_0000, 32'h8000_0000, 1'b1, 1'b1, 5'd14);
    tick();
    expect_all("add_ovf_neg", 1'b1, 32'h0, 1'b1, 1'b1, !TRAP, 5'd14, TRAP);
    Flush = 1'b1;
    tick();
    expect_all("flush", 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0);
    Flush = 1'b0;

    // 6. reset mid-stream while stalled with valid ops queued
    set_in(3'b001, 32'hA, 32'h5, 1'b1, 1'b1, 5'd15);
    tick();
    expect_all("pre_reset", 1'b1, 32'hF, 1'b0, 1'b0, 1'b1, 5'd15, 1'b0);
    Stall = 1'b1; Reset = 1'b1;
    set_in(3'b010, 32'd40, 32'd2, 1'b1, 1'b1, 5'd16);
    tick();
    expect_all("mid_reset", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
    Reset = 1'b0; Stall = 1'b0;
    tick();
    expect_all("resume", 1'b1, 32'd42, 1'b0, 1'b0, 1'b1, 5'd16, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
